// File: rtl/bus_pkg.sv
// Shared data-bus definitions: responder state encoding, legal byte-lane masks,
// the default data-window base address, and small decode helpers.
package bus_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  function automatic logic be_legal(input logic [3:0] be);
    return be inside {BE_WORD, BE_HALF_LO, BE_HALF_HI,
                      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3};
  endfunction

  // 33-bit arithmetic so a window touching the top of the address space cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] span);
    logic [32:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return !offset[32] && (offset < span);
  endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Data-bus bundle between the datapath (master) and the memory responder (slave).
interface bus_mem_responder_if;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] oReadData;
  logic        oReadValid;
  logic        oBusy;
  logic        oHit;
  logic        oError;
  logic [15:0] oErrCount;

  modport master (
    output iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    input  oReadData, oReadValid, oBusy, oHit, oError, oErrCount
  );

  modport slave (
    input  iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    output oReadData, oReadValid, oBusy, oHit, oError, oErrCount
  );
endinterface

// File: rtl/mem_word_array.sv
// Word-organised storage with per-byte-lane write enables and a registered
// (synchronous) read port that holds its value until the next read.
module mem_word_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] idx_i,
  input  logic [3:0]    lane_we_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto RAM macros; only the read register is reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Data-memory responder: window decode, byte-lane writes, fixed-latency read
// handshake, and flagging/counting of illegal accesses.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 1
) (
  input logic                iCLK,
  input logic                iRST_n,
  bus_mem_responder_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  CNT_LOAD = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        valid_q;
  logic        busy_q;
  logic        miss_q;
  logic        err_q;
  logic        err_d;
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  logic          hit;
  logic          mask_ok;
  logic          wr_req;
  logic          rd_req;
  logic          commit;
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic          unused_offset_bits;

  assign hit                = in_window(bus.iAddress, BASE_ADDR, SPAN);
  assign mask_ok            = be_legal(bus.iByteEnable);
  assign offset             = bus.iAddress - BASE_ADDR;
  assign word_idx           = offset[AW+1:2];
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

  // Requests are only looked at in IDLE; a write always takes priority over a read.
  assign wr_req = (state_q == IDLE) && bus.iWriteEnable;
  assign rd_req = (state_q == IDLE) && !bus.iWriteEnable && bus.iReadEnable;
  assign commit = wr_req && hit && mask_ok;

  // Gating with the reset keeps a write from landing on an edge while reset is held.
  assign lane_we = (commit && iRST_n) ? bus.iByteEnable : 4'b0000;
  assign mem_re  = rd_req && hit;

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (wr_req && (!hit || !mask_ok || bus.iReadEnable)) err_d = 1'b1;
    if (rd_req && !hit)                                   err_d = 1'b1;
    if (err_d && (err_cnt_q != 16'hFFFF))                 err_cnt_d = err_cnt_q + 16'd1;
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .idx_i    (word_idx),
    .lane_we_i(lane_we),
    .wdata_i  (bus.iWriteData),
    .re_i     (mem_re),
    .rdata_o  (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      miss_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (rd_req) begin
            miss_q <= !hit;
            busy_q <= 1'b1;
            if (READ_LATENCY == 1) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          if (!bus.iReadEnable) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // An out-of-window read returns zero without touching the memory's read register.
  assign bus.oReadData  = miss_q ? 32'h0 : mem_rdata;
  assign bus.oReadValid = valid_q;
  assign bus.oBusy      = busy_q;
  assign bus.oHit       = hit;
  assign bus.oError     = err_q;
  assign bus.oErrCount  = err_cnt_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed scenarios plus a random
// phase, all compared against a word-array reference model kept here.
module tb_bus_mem_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [31:0] model_mem [int];
  int          model_err;

  bus_mem_responder_if bus ();

  bus_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .iCLK  (clk),
    .iRST_n(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 4);
  endfunction

  function automatic bit model_legal(input logic [3:0] be);
    return be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  function automatic void model_error();
    if (model_err < 65535) model_err++;
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] be);
    logic [31:0] w;
    int idx;
    idx = model_idx(addr);
    w   = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = data[8*k +: 8];
    model_mem[idx] = w;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "/valid"}, 32'(bus.oReadValid), 32'h0);
    check({tag, "/busy"},  32'(bus.oBusy),      32'h0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input string tag);
    bit ok;
    ok = model_hit(addr) && model_legal(be);
    bus.iAddress     = addr;
    bus.iWriteData   = data;
    bus.iByteEnable  = be;
    bus.iWriteEnable = 1'b1;
    step();
    bus.iWriteEnable = 1'b0;
    if (ok) model_store(addr, data, be);
    else    model_error();
    check({tag, "/err"},    32'(bus.oError),    32'(!ok));
    check({tag, "/errcnt"}, 32'(bus.oErrCount), 32'(model_err));
    check({tag, "/busy"},   32'(bus.oBusy),     32'h0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, input string tag);
    logic [31:0] exp;
    bit hit;
    hit = model_hit(addr);
    exp = hit ? model_mem[model_idx(addr)] : 32'h0;
    bus.iAddress     = addr;
    bus.iByteEnable  = 4'(4'($urandom_range(0, 15)));
    bus.iReadEnable  = 1'b1;
    step();
    if (!hit) model_error();
    check({tag, "/acc_err"},    32'(bus.oError),    32'(!hit));
    check({tag, "/acc_errcnt"}, 32'(bus.oErrCount), 32'(model_err));
    check({tag, "/acc_busy"},   32'(bus.oBusy),     32'h1);
    for (int i = 1; i < LAT; i++) begin
      check({tag, "/early_valid"}, 32'(bus.oReadValid), 32'h0);
      step();
    end
    check({tag, "/valid"}, 32'(bus.oReadValid), 32'h1);
    check({tag, "/data"},  bus.oReadData,       exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "/hold_valid"}, 32'(bus.oReadValid), 32'h1);
      check({tag, "/hold_busy"},  32'(bus.oBusy),      32'h1);
      check({tag, "/hold_data"},  bus.oReadData,       exp);
    end
    bus.iReadEnable = 1'b0;
    step();
    check_idle_outputs({tag, "/done"});
    check({tag, "/kept_data"}, bus.oReadData, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          op;

    vectors          = 0;
    miscompares      = 0;
    model_err        = 0;
    rst_n            = 1'b0;
    bus.iAddress     = 32'h0;
    bus.iWriteData   = 32'h0;
    bus.iWriteEnable = 1'b0;
    bus.iReadEnable  = 1'b0;
    bus.iByteEnable  = 4'h0;

    #3;
    check("rst/data",   bus.oReadData,         32'h0);
    check("rst/valid",  32'(bus.oReadValid),   32'h0);
    check("rst/busy",   32'(bus.oBusy),        32'h0);
    check("rst/err",    32'(bus.oError),       32'h0);
    check("rst/errcnt", 32'(bus.oErrCount),    32'h0);
    #19 rst_n = 1'b1;

    bus.iAddress = BASE;             #1 check("hit/base",     32'(bus.oHit), 32'h1);
    bus.iAddress = BASE - 32'd1;     #1 check("hit/below",    32'(bus.oHit), 32'h0);
    bus.iAddress = BASE + 32'd4095;  #1 check("hit/top",      32'(bus.oHit), 32'h1);
    bus.iAddress = BASE + 32'd4096;  #1 check("hit/past_top", 32'(bus.oHit), 32'h0);
    bus.iAddress = 32'h0;            #1 check("hit/zero",     32'(bus.oHit), 32'h0);

    do_write(32'h1001_0010, 32'hDEAD_BEEF, 4'b1111, "full_wr");
    do_read (32'h1001_0010, 0, "full_rd");

    do_write(32'h1001_0020, 32'h1122_3344, 4'b1111, "merge_init");
    do_write(32'h1001_0020, 32'h0000_AA00, 4'b0010, "merge_b1");
    do_read (32'h1001_0020, 0, "merge_rd1");
    check("merge_rd1/spec", bus.oReadData, 32'h1122_AA44);
    do_write(32'h1001_0020, 32'h5566_0000, 4'b1100, "merge_hi");
    do_read (32'h1001_0020, 0, "merge_rd2");
    check("merge_rd2/spec", bus.oReadData, 32'h5566_AA44);

    do_write(32'h1001_0020, 32'hFFFF_FFFF, 4'b0110, "ill_mask");
    check("ill_mask/cnt_spec", 32'(bus.oErrCount), 32'd1);
    do_read (32'h1001_0020, 0, "ill_mask_rd");
    check("ill_mask_rd/spec", bus.oReadData, 32'h5566_AA44);
    do_write(32'h1000_FFFC, 32'h1234_5678, 4'b1111, "ill_addr");
    check("ill_addr/cnt_spec", 32'(bus.oErrCount), 32'd2);
    do_read (32'h0000_0000, 0, "ill_rd");
    check("ill_rd/cnt_spec", 32'(bus.oErrCount), 32'd3);

    // Write and read asserted together in IDLE: write commits, read is dropped.
    bus.iAddress     = 32'h1001_0030;
    bus.iWriteData   = 32'hCAFE_F00D;
    bus.iByteEnable  = 4'b1111;
    bus.iWriteEnable = 1'b1;
    bus.iReadEnable  = 1'b1;
    step();
    bus.iWriteEnable = 1'b0;
    bus.iReadEnable  = 1'b0;
    model_store(32'h1001_0030, 32'hCAFE_F00D, 4'b1111);
    model_error();
    check("collide/err",    32'(bus.oError),    32'h1);
    check("collide/errcnt", 32'(bus.oErrCount), 32'(model_err));
    check_idle_outputs("collide");
    step();
    check("collide/err_drop", 32'(bus.oError), 32'h0);
    do_read(32'h1001_0030, 0, "collide_rd");

    // Write presented while the read sits in WAIT must be ignored.
    bus.iAddress    = 32'h1001_0030;
    bus.iReadEnable = 1'b1;
    step();
    bus.iWriteData   = 32'h0BAD_0BAD;
    bus.iByteEnable  = 4'b1111;
    bus.iWriteEnable = 1'b1;
    step();
    bus.iWriteEnable = 1'b0;
    check("wait_wr/err",   32'(bus.oError),     32'h0);
    check("wait_wr/valid", 32'(bus.oReadValid), 32'h1);
    check("wait_wr/data",  bus.oReadData,       32'hCAFE_F00D);
    bus.iReadEnable = 1'b0;
    step();
    do_read(32'h1001_0030, 0, "wait_wr_rd");

    do_read(32'h1001_0010, 5, "hold5");

    for (int i = 0; i < 16; i++)
      do_write(BASE + 32'h100 + 32'(4 * i), $urandom, 4'b1111, "rnd_init");
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 9));
      a  = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      if (op == 9) a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'd4096 + 32'(4 * $urandom_range(0, 255));
      if (op < 5 || (op == 9 && be[0])) do_write(a, d, be, "rnd_wr");
      else                              do_read (a, int'($urandom_range(0, 2)), "rnd_rd");
    end

    // Reset asserted while a read waits in WAIT.
    do_write(32'h1001_0040, 32'h0F1E_2D3C, 4'b1111, "rst_prep");
    bus.iAddress    = 32'h1001_0040;
    bus.iReadEnable = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    model_err = 0;
    check("midrst/data",   bus.oReadData,       32'h0);
    check("midrst/valid",  32'(bus.oReadValid), 32'h0);
    check("midrst/busy",   32'(bus.oBusy),      32'h0);
    check("midrst/err",    32'(bus.oError),     32'h0);
    check("midrst/errcnt", 32'(bus.oErrCount),  32'h0);
    bus.iReadEnable = 1'b0;
    #10 rst_n = 1'b1;
    do_read(32'h1001_0040, 0, "midrst_rd");

    // Hold an illegal-mask write long enough to run the counter into saturation.
    bus.iAddress     = BASE;
    bus.iWriteData   = 32'h0;
    bus.iByteEnable  = 4'b0110;
    bus.iWriteEnable = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      step();
      model_error();
    end
    check("sat/err",    32'(bus.oError),    32'h1);
    check("sat/errcnt", 32'(bus.oErrCount), 32'(model_err));
    check("sat/spec",   32'(bus.oErrCount), 32'h0000_FFFF);
    bus.iWriteEnable = 1'b0;
    step();
    check("sat/err_drop", 32'(bus.oError), 32'h0);
    do_write(32'h0000_1000, 32'h0, 4'b1111, "sat_more");
    check("sat_more/spec", 32'(bus.oErrCount), 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
